// File: rtl/pokey_timer_sequencer.sv
// POKEY audio channel timer sequencer: register decode, divide-by-N counters, 8/16-bit linking.
// Optional IRQ pending logic is built only when POKEY_TIMER_IRQ_EN is defined.
module pokey_timer_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable_179,
   input  logic        enable_64,
   input  logic        enable_15,
   input  logic        wr_en,
   input  logic [3:0]  addr,
   input  logic [7:0]  data_in,
   output logic [3:0]  pulse_out,
   output logic [11:0] noise_select,
   output logic [15:0] volume,
   output logic [3:0]  vol_only,
   output logic        poly9_sel,
   output logic        sync_reset,
   output logic [2:0]  irq_timer
);

   logic [7:0]  audf_q [4];
   logic [7:0]  audc_q [4];
   logic [7:0]  audctl_q;
   logic [16:0] cnt_q  [4];
   logic [16:0] cnt_d  [4];
   logic [16:0] reload_s [4];
   logic [3:0]  tick_s;
   logic [3:0]  fast_s;
   logic [1:0]  link_s;
   logic [3:0]  pulse_q;
   logic [3:0]  pulse_d;
   logic        sync_q;
   logic        base_s;
   logic        stimer_s;

   assign stimer_s = wr_en && (addr == 4'd9);

   // Tick source selection and reload values; a linked pair counts in the low channel's counter
   always_comb begin
      base_s    = audctl_q[0] ? enable_15 : enable_64;
      tick_s[0] = audctl_q[6] ? enable_179 : base_s;
      tick_s[1] = base_s;
      tick_s[2] = audctl_q[5] ? enable_179 : base_s;
      tick_s[3] = base_s;
      fast_s    = {1'b0, audctl_q[5], 1'b0, audctl_q[6]};
      link_s    = {audctl_q[3], audctl_q[4]};
      for (int p = 0; p < 2; p++) begin
         reload_s[2*p+1] = {9'd0, audf_q[2*p+1]};
         if (link_s[p]) begin
            reload_s[2*p] = {1'b0, audf_q[2*p+1], audf_q[2*p]} + (fast_s[2*p] ? 17'd6 : 17'd0);
         end else begin
            reload_s[2*p] = {9'd0, audf_q[2*p]} + (fast_s[2*p] ? 17'd3 : 17'd0);
         end
      end
   end

   // Counter next state; STIMER reloads everything and swallows any coincident tick
   always_comb begin
      pulse_d = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (stimer_s) begin
         for (int i = 0; i < 4; i++) begin
            cnt_d[i] = reload_s[i];
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (link_s[p]) begin
               if (tick_s[2*p]) begin
                  if (cnt_q[2*p] == 17'd0) begin
                     pulse_d[2*p+1] = 1'b1;
                     cnt_d[2*p]     = reload_s[2*p];
                  end else begin
                     cnt_d[2*p] = cnt_q[2*p] - 17'd1;
                  end
               end else begin
                  cnt_d[2*p] = cnt_q[2*p];
               end
            end else begin
               for (int c = 2*p; c < 2*p+2; c++) begin
                  if (tick_s[c]) begin
                     if (cnt_q[c] == 17'd0) begin
                        pulse_d[c] = 1'b1;
                        cnt_d[c]   = reload_s[c];
                     end else begin
                        cnt_d[c] = cnt_q[c] - 17'd1;
                     end
                  end else begin
                     cnt_d[c] = cnt_q[c];
                  end
               end
            end
         end
      end
   end

   // Counter, pulse and sync state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= 17'd0;
         end
         pulse_q <= 4'b0000;
         sync_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         pulse_q <= pulse_d;
         sync_q  <= stimer_s;
      end
   end

   // CPU register file decode
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            audf_q[i] <= 8'd0;
            audc_q[i] <= 8'd0;
         end
         audctl_q <= 8'd0;
      end else if (wr_en) begin
         case (addr)
            4'd0, 4'd2, 4'd4, 4'd6: audf_q[addr[2:1]] <= data_in;
            4'd1, 4'd3, 4'd5, 4'd7: audc_q[addr[2:1]] <= data_in;
            4'd8:                   audctl_q          <= data_in;
            default:                ;
         endcase
      end
   end

`ifdef POKEY_TIMER_IRQ_EN
   logic [2:0] irqen_q;
   logic [2:0] irq_q;
   logic [2:0] irq_d;
   logic [2:0] irq_clr_s;

   // Pending bits set from the registered pulse; a same-cycle IRQEN clear overrides the set
   always_comb begin
      irq_clr_s = (wr_en && (addr == 4'd14)) ? ~data_in[2:0] : 3'b000;
      irq_d     = (irq_q | ({pulse_q[3], pulse_q[1], pulse_q[0]} & irqen_q)) & ~irq_clr_s;
   end

   // IRQ enable and pending state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqen_q <= 3'b000;
         irq_q   <= 3'b000;
      end else begin
         if (wr_en && (addr == 4'd14)) begin
            irqen_q <= data_in[2:0];
         end
         irq_q <= irq_d;
      end
   end

   assign irq_timer = irq_q;
`else
   assign irq_timer = 3'b000;
`endif

   assign pulse_out    = pulse_q;
   assign sync_reset   = sync_q;
   assign poly9_sel    = audctl_q[7];
   assign noise_select = {audc_q[3][7:5], audc_q[2][7:5], audc_q[1][7:5], audc_q[0][7:5]};
   assign volume       = {audc_q[3][3:0], audc_q[2][3:0], audc_q[1][3:0], audc_q[0][3:0]};
   assign vol_only     = {audc_q[3][4], audc_q[2][4], audc_q[1][4], audc_q[0][4]};

endmodule

// File: tb/tb_pokey_timer_sequencer.sv
// Directed self-checking bench for pokey_timer_sequencer.
module tb_pokey_timer_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable_179 = 1'b0;
   logic        enable_64 = 1'b0;
   logic        enable_15 = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  addr = 4'd0;
   logic [7:0]  data_in = 8'd0;
   logic [3:0]  pulse_out;
   logic [11:0] noise_select;
   logic [15:0] volume;
   logic [3:0]  vol_only;
   logic        poly9_sel;
   logic        sync_reset;
   logic [2:0]  irq_timer;

   int total = 0;
   int bad = 0;

`ifdef POKEY_TIMER_IRQ_EN
   localparam logic [2:0] IRQ_CH2 = 3'b010;
`else
   localparam logic [2:0] IRQ_CH2 = 3'b000;
`endif

   pokey_timer_sequencer dut (
      .clk(clk), .reset_n(reset_n), .enable_179(enable_179), .enable_64(enable_64),
      .enable_15(enable_15), .wr_en(wr_en), .addr(addr), .data_in(data_in),
      .pulse_out(pulse_out), .noise_select(noise_select), .volume(volume),
      .vol_only(vol_only), .poly9_sel(poly9_sel), .sync_reset(sync_reset),
      .irq_timer(irq_timer)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      wr_en = 1'b1; addr = a; data_in = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic t64();
      enable_64 = 1'b1; step(); enable_64 = 1'b0;
   endtask

   task automatic t179();
      enable_179 = 1'b1; step(); enable_179 = 1'b0;
   endtask

   initial begin
      // reset state
      step(); step();
      chk("rst_pulse", 32'(pulse_out), 32'h0);
      chk("rst_sync", 32'(sync_reset), 32'h0);
      chk("rst_irq", 32'(irq_timer), 32'h0);
      chk("rst_vol", 32'(volume), 32'h0);
      reset_n = 1'b1;
      step();

      // after reset every channel pulses on each base tick; enable_15 is not selected
      t64();
      chk("rst_every_tick", 32'(pulse_out), 32'hF);
      enable_15 = 1'b1; step(); enable_15 = 1'b0;
      chk("e15_ignored", 32'(pulse_out), 32'h0);

      // ch1 divide by 10 on enable_64
      wr(4'd0, 8'd9);
      wr(4'd8, 8'h00);
      wr(4'd9, 8'h00);
      chk("sync_hi", 32'(sync_reset), 32'h1);
      step();
      chk("sync_lo", 32'(sync_reset), 32'h0);
      for (int i = 1; i <= 20; i++) begin
         t64();
         chk("ch1_div10", 32'(pulse_out[0]), 32'((i % 10) == 0));
      end

      // ch1 on 1.79 MHz: period 9+4
      wr(4'd8, 8'h40);
      wr(4'd9, 8'h00);
      for (int i = 1; i <= 26; i++) begin
         t179();
         chk("ch1_fast13", 32'(pulse_out), 32'((i % 13) == 0));
      end

      // linked ch1+2 on 1.79 MHz: period 0x1234+7
      wr(4'd8, 8'h50);
      wr(4'd0, 8'h34);
      wr(4'd2, 8'h12);
      wr(4'd9, 8'h00);
      for (int i = 1; i <= 2 * 4667; i++) begin
         t179();
         chk("link12", 32'(pulse_out), ((i % 4667) == 0) ? 32'h2 : 32'h0);
      end

      // AUDF3 rewritten mid-count applies at next reload
      wr(4'd8, 8'h00);
      wr(4'd4, 8'd20);
      wr(4'd9, 8'h00);
      for (int i = 1; i <= 29; i++) begin
         if (i == 6) wr(4'd4, 8'd3);
         t64();
         chk("ch3_midwrite", 32'(pulse_out[2]), 32'((i == 21) || (i == 25) || (i == 29)));
      end

      // STIMER coincident with a ch1 zero tick
      wr(4'd0, 8'd2);
      wr(4'd9, 8'h00);
      t64();
      t64();
      wr_en = 1'b1; addr = 4'd9; data_in = 8'h00; enable_64 = 1'b1;
      step();
      wr_en = 1'b0; enable_64 = 1'b0;
      chk("stimer_nopulse", 32'(pulse_out[0]), 32'h0);
      chk("stimer_sync", 32'(sync_reset), 32'h1);
      for (int i = 1; i <= 3; i++) begin
         t64();
         chk("stimer_reload", 32'(pulse_out[0]), 32'(i == 3));
      end

      // IRQ: ch2 sets its pending bit, IRQEN clear drops it, clear beats set
      wr(4'd8, 8'h40);
      wr(4'd2, 8'd0);
      wr(4'd6, 8'd5);
      wr(4'd9, 8'h00);
      wr(4'd14, 8'h07);
      chk("irq_idle", 32'(irq_timer), 32'h0);
      t64();
      chk("irq_ch2_pulse", 32'(pulse_out), 32'h2);
      chk("irq_not_yet", 32'(irq_timer), 32'h0);
      step();
      chk("irq_ch2_set", 32'(irq_timer), 32'(IRQ_CH2));
      wr(4'd14, 8'h05);
      chk("irq_cleared", 32'(irq_timer), 32'h0);
      wr(4'd14, 8'h07);
      t64();
      wr(4'd14, 8'h05);
      chk("irq_clear_wins", 32'(irq_timer), 32'h0);
      step();
      chk("irq_stays_clear", 32'(irq_timer), 32'h0);

      // AUDC / AUDCTL decode
      wr(4'd1, 8'hB7);
      chk("audc1_noise", 32'(noise_select), 32'h005);
      chk("audc1_vol", 32'(volume), 32'h0007);
      chk("audc1_volonly", 32'(vol_only), 32'h1);
      wr(4'd7, 8'h4A);
      chk("audc4_noise", 32'(noise_select), 32'h405);
      chk("audc4_vol", 32'(volume), 32'hA007);
      chk("audc4_volonly", 32'(vol_only), 32'h1);
      wr(4'd8, 8'h80);
      chk("poly9", 32'(poly9_sel), 32'h1);
      wr(4'd11, 8'hFF);
      chk("unmapped_ignored", 32'(volume), 32'hA007);

      // asynchronous reset mid-run
      reset_n = 1'b0;
      #1;
      chk("async_vol", 32'(volume), 32'h0);
      chk("async_noise", 32'(noise_select), 32'h0);
      chk("async_poly9", 32'(poly9_sel), 32'h0);
      chk("async_pulse", 32'(pulse_out), 32'h0);
      step();
      reset_n = 1'b1;
      step();
      t64();
      chk("post_rst_tick", 32'(pulse_out), 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
